// File: rtl/mult_unit_if.sv
// mult_unit_if: operand/result bundle between the control path and mult_unit.
//   start  : issue MULTU with operands a, b (taken only while busy=0)
//   a, b   : multiplicand (rs) and multiplier (rt)
//   rdsel  : 0 selects LO, 1 selects HI onto rddata (MFLO / MFHI)
//   busy   : multiply in progress; the issuer stalls MULTU/MFHI/MFLO
//   done   : one-cycle pulse, HI/LO were written at the preceding edge
//   hi, lo : architectural HI/LO registers
//   rddata : combinational HI/LO read mux for write-back
// master = control path / issuer, slave = multiplier.
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rdsel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rddata;

  modport master (
    output start, a, b, rdsel,
    input  busy, done, hi, lo, rddata
  );

  modport slave (
    input  start, a, b, rdsel,
    output busy, done, hi, lo, rddata
  );
endinterface

// File: rtl/mult_unit.sv
// mult_unit: iterative unsigned multiplier with architectural HI/LO registers.
// One shift-add step per clock; a WIDTH x WIDTH product takes WIDTH RUN cycles
// after the accept edge. busy stays high from the accept edge until the edge
// that commits {hi,lo}; done pulses for the single cycle after that commit.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears all state including HI/LO
//   bus   : mult_unit_if slave (start, a, b, rdsel in; busy, done, hi, lo,
//           rddata out)
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  mult_unit_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]         state;
  logic [CW-1:0]      counter;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_next;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               last_step;

  // One shift-add step. The upper half plus the conditional multiplicand is
  // formed WIDTH+1 bits wide so the carry survives the right shift; dropping
  // it would corrupt products whose running upper half overflows.
  function automatic logic [2*WIDTH-1:0] shift_add_step(
    input logic [2*WIDTH-1:0] p,
    input logic [WIDTH-1:0]   m
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, p[WIDTH-1:1]};
  endfunction

  always_comb begin
    prod_next = shift_add_step(prod, mcand);
    last_step = (counter == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      mcand    <= '0;
      prod     <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      hi_reg   <= '0;
      lo_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_reg <= 1'b0;
          // Accept in the done cycle too, so back-to-back multiplies have no gap.
          if (bus.start) begin
            mcand    <= bus.a;
            prod     <= {{WIDTH{1'b0}}, bus.b};
            counter  <= '0;
            busy_reg <= 1'b1;
            state    <= RUN;
          end
        end
        default: begin
          // start is deliberately ignored here; operands are already latched.
          done_reg <= 1'b0;
          prod     <= prod_next;
          counter  <= counter + CW'(1);
          if (last_step) begin
            hi_reg   <= prod_next[2*WIDTH-1:WIDTH];
            lo_reg   <= prod_next[WIDTH-1:0];
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.hi     = hi_reg;
  assign bus.lo     = lo_reg;
  // HI/LO keep their old values during RUN; the consumer must stall on busy.
  assign bus.rddata = bus.rdsel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed bench for mult_unit (WIDTH=32). Inputs are driven
// and outputs sampled on the falling clock edge.
module tb_mult_unit;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [W-1:0] prev_hi;
  logic [W-1:0] prev_lo;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait while busy, counting busy cycles from the first falling edge after
  // the accept edge; bounded so a stuck busy cannot hang the run.
  task automatic wait_busy(input string tag, output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      if (bus.done === 1'b1) dones++;
      if (cyc == 5) begin
        chk({tag, "_old_hi"}, bus.hi, prev_hi);
        chk({tag, "_old_lo"}, bus.lo, prev_lo);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_mul(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
    int cyc;
    int dones;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    chk({tag, "_busy_after_accept"}, bus.busy, 1);
    wait_busy(tag, cyc, dones);
    chk({tag, "_latency"}, cyc, 32);
    chk({tag, "_early_done"}, dones, 0);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    prev_hi = eh;
    prev_lo = el;
    @(negedge clk);
    chk({tag, "_done_cleared"}, bus.done, 0);
  endtask

  initial begin
    int cyc;
    int dones;
    checks = 0;
    failures = 0;
    prev_hi = '0;
    prev_lo = '0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.rdsel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_rddata", bus.rddata, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: 3*5
    run_mul("t1", 32'd3, 32'd5, 32'd0, 32'd15);
    bus.rdsel = 1'b0;
    #1 chk("t1_mflo", bus.rddata, 32'd15);
    bus.rdsel = 1'b1;
    #1 chk("t1_mfhi", bus.rddata, 32'd0);
    @(negedge clk);

    // 2: max*max, needs the carry out of each add
    run_mul("t2", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    bus.rdsel = 1'b1;
    #1 chk("t2_mfhi", bus.rddata, 32'hFFFFFFFE);

    // 3: zero operands still take the full latency
    run_mul("t3a", 32'h12345678, 32'h0, 32'h0, 32'h0);
    run_mul("t3b", 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);

    // 4: start during busy is ignored
    bus.a = 32'd7;
    bus.b = 32'd6;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_busy("t4", cyc, dones);
    chk("t4_latency", cyc, 27);
    chk("t4_lo", bus.lo, 32'd42);
    chk("t4_hi", bus.hi, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("t4_single_done", dones, 1);
    chk("t4_idle", bus.busy, 0);
    prev_hi = 32'd0;
    prev_lo = 32'd42;

    // 5: start held into the done cycle -> back-to-back accept
    bus.a = 32'h10000;
    bus.b = 32'h10000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.a = 32'd2;
    bus.b = 32'd3;
    wait_busy("t5a", cyc, dones);
    chk("t5a_latency", cyc, 32);
    chk("t5a_done", bus.done, 1);
    chk("t5a_hi", bus.hi, 32'd1);
    chk("t5a_lo", bus.lo, 32'd0);
    prev_hi = 32'd1;
    prev_lo = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5b_no_gap_busy", bus.busy, 1);
    chk("t5b_done_cleared", bus.done, 0);
    wait_busy("t5b", cyc, dones);
    chk("t5b_latency", cyc, 32);
    chk("t5b_done", bus.done, 1);
    chk("t5b_hi", bus.hi, 32'd0);
    chk("t5b_lo", bus.lo, 32'd6);
    prev_hi = 32'd0;
    prev_lo = 32'd6;
    @(negedge clk);

    // 6: reset mid-RUN aborts and clears HI/LO
    run_mul("t6pre", 32'h10000, 32'h10000, 32'd1, 32'd0);
    bus.a = 32'd5;
    bus.b = 32'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t6_busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_hi", bus.hi, 0);
    chk("t6_lo", bus.lo, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    chk("t6_no_late_done", dones, 0);
    chk("t6_hi_stays", bus.hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
